matmul_engine: RTL and testbench
================================

# matmul_engine

Parametrised, sequential NxN signed matrix-multiply engine that computes C = A × B from on-chip operand registers. Operands are loaded through a write port, a start/busy/done handshake controls the run, results are read back through an address port, and a cycle counter reports the run length. It sits beside the single-cycle RISC-V core as a memory-mapped accelerator and replaces the fixed one-cycle 2x2 multiplier.

## Interface
- N, 2: matrix dimension; legal range 2..8.
- DW, 8: element width of A and B (signed two's complement).
- ACCW, 32: accumulator and result width; must satisfy ACCW ≥ 2·DW + clog2(N).
- AW (localparam), clog2(N·N): element address width; address = row·N + col.

- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- a_we  in  1  write data_in into A[w_addr]
- b_we  in  1  write data_in into B[w_addr]
- w_addr  in  AW  operand element address
- data_in  in  DW  operand element value
- start  in  1  request a run; sampled only in IDLE
- relu  in  1  clamp negative results to 0 for this run; sampled with start
- busy  out  1  run in progress
- done  out  1  one-cycle pulse when C is complete
- r_addr  in  AW  result element address
- r_data  out  ACCW  C[r_addr], combinational read
- cycle_count  out  32  number of MAC cycles in the last completed run

## Operation
- FSM states: IDLE, MAC, DONE.
- IDLE: accepts operand writes. When start=1: clear indices i, j, k and the accumulator, latch relu, clear cycle_count, then go to MAC.
- MAC: one multiply-accumulate per cycle, acc += sext(A[i][k]·B[k][j]) using a full 2·DW signed product.
  - cycle_count increments every MAC cycle.
  - When k = N−1: write acc + product (after ReLU if enabled) into C[i][j], clear acc, set k = 0, advance j; when j wraps, advance i.
  - After C[N−1][N−1] is written, go to DONE.
- DONE: one cycle with done=1, then return to IDLE.
- Arithmetic: accumulation wraps modulo 2^ACCW; no saturation.
- Operand writes (a_we/b_we) while busy=1 are ignored. a_we and b_we may both be high; both arrays take data_in.
- start while busy or in DONE is ignored. It is not queued.
- w_addr ≥ N·N: the write is ignored. r_addr ≥ N·N: r_data = 0.
- r_data is undefined while busy=1 (partial C). It is stable from done until the next start.
- C is not cleared by start; each element is overwritten during the run.

## Timing
- Reset values: busy=0, done=0, cycle_count=0, r_data=0 for every address, and state=IDLE. A, B and C are all zeroed.
- start sampled high at edge t: busy=1 from t+1 through t+N³; done=1 in cycle t+N³+1, with busy=0 in that cycle; IDLE from t+N³+2.
- Total latency from start to done is N³+1 cycles; a new start is accepted in the cycle after done.
- cycle_count = N³ when done is asserted, and holds until the next start.
- C[i][j] becomes readable one cycle after its final MAC.
- Reset mid-run: immediate return to IDLE with all arrays zeroed; no done pulse.

## Configuration
- MATMUL_RELU_EN defined: when the latched relu=1, any negative final C element is written as 0. relu=0 writes the raw result.
- MATMUL_RELU_EN undefined: the relu input is ignored and the clamp logic is not built; C always holds the raw signed result.

## Structure
- Package matmul_pkg holds:
  - the state enum (IDLE, MAC, DONE);
  - the default values of N, DW and ACCW;
  - an AW helper function (clog2 of N·N).
- Sub-module matmul_mac contains the signed DW×DW multiplier, the ACCW-wide accumulator with clear and load controls, and the optional ReLU clamp. The top level holds the FSM, the index counters, the three register arrays and cycle_count.

## Test plan
- N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], start → busy high for 8 cycles, done on the 9th, C=[[19,22],[43,50]], cycle_count=8.
- N=2, A all −128, B all −128 → every C element = 32768; N=4 with A=identity, B=0..15 → C equals B.
- MATMUL_RELU_EN, A=[[−1,0],[0,1]], B=identity: relu=1 → C=[[0,0],[0,1]]; relu=0 → C=[[−1,0],[0,1]] (C00 = 0xFFFFFFFF).
- During a run, start=1 and a_we=1 at w_addr 0 → neither has any effect: the result is unchanged, and exactly one done pulse occurs at cycle N³+1.
- rst_n pulsed low at MAC cycle 3 → busy=0 immediately, no done pulse, all r_data=0, cycle_count=0; a fresh load and start then completes correctly.
- N=3: w_addr=9 write ignored; r_addr=12 read → 0; legal addresses unaffected.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul_engine accelerator: FSM state encoding,
// default dimensions and the element-address width helper.
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int N_DEF    = 2;
  localparam int DW_DEF   = 8;
  localparam int ACCW_DEF = 32;

  // Element address width for an n x n matrix stored row-major
  function automatic int aw_of(input int n);
    return $clog2(n * n);
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Multiply-accumulate datapath for matmul_engine: signed DW x DW product,
// ACCW-wide wrapping accumulator and the optional negative-result clamp.
// Optional feature macro: MATMUL_RELU_EN (builds the ReLU clamp).
module matmul_mac #(
  parameter int DW   = 8,
  parameter int ACCW = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   en,
  input  logic                   last,
  input  logic                   relu_en,
  input  logic signed [DW-1:0]   a,
  input  logic signed [DW-1:0]   b,
  output logic [ACCW-1:0]        result
);

  logic signed [2*DW-1:0] prod_s;
  logic [ACCW-1:0]        sum_s;
  logic [ACCW-1:0]        acc_r;

`ifndef MATMUL_RELU_EN
  logic relu_unused_s;
  assign relu_unused_s = relu_en;
`endif

  // Full-width signed product, sign-extended sum and final element value
  always_comb begin
    prod_s = a * b;
    sum_s  = acc_r + {{(ACCW-2*DW){prod_s[2*DW-1]}}, prod_s};
`ifdef MATMUL_RELU_EN
    if (relu_en && sum_s[ACCW-1]) begin
      result = {ACCW{1'b0}};
    end else begin
      result = sum_s;
    end
`else
    result = sum_s;
`endif
  end

  // Accumulator: cleared at run start and after each finished element
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= {ACCW{1'b0}};
    end else if (clr) begin
      acc_r <= {ACCW{1'b0}};
    end else if (en) begin
      if (last) begin
        acc_r <= {ACCW{1'b0}};
      end else begin
        acc_r <= sum_s;
      end
    end
  end

endmodule

// File: rtl/matmul_engine.sv
// matmul_engine: sequential NxN signed matrix multiply C = A x B with
// operand write port, start/busy/done handshake and result read port.
// Optional feature macro: MATMUL_RELU_EN (clamp negative C elements when
// relu is latched high at start).
module matmul_engine
  import matmul_pkg::*;
#(
  parameter  int N    = N_DEF,
  parameter  int DW   = DW_DEF,
  parameter  int ACCW = ACCW_DEF,
  localparam int AW   = aw_of(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                a_we,
  input  logic                b_we,
  input  logic [AW-1:0]       w_addr,
  input  logic [DW-1:0]       data_in,
  input  logic                start,
  input  logic                relu,
  output logic                busy,
  output logic                done,
  input  logic [AW-1:0]       r_addr,
  output logic [ACCW-1:0]     r_data,
  output logic [31:0]         cycle_count
);

  localparam int NN = N * N;
  localparam int IW = $clog2(N);

  state_t                 state_r;
  logic [IW-1:0]          i_r, j_r, k_r;
  logic                   relu_r;
  logic                   busy_r, done_r;
  logic [31:0]            cycle_count_r;
  logic signed [DW-1:0]   a_mem_r [NN];
  logic signed [DW-1:0]   b_mem_r [NN];
  logic [ACCW-1:0]        c_mem_r [NN];

  logic [AW-1:0]          a_idx_s, b_idx_s, c_idx_s;
  logic signed [DW-1:0]   a_op_s, b_op_s;
  logic                   mac_clr_s, mac_en_s, mac_last_s;
  logic                   w_ok_s, r_ok_s;
  logic [ACCW-1:0]        mac_result_s;

  // Operand selection, MAC controls, address range checks and result read
  always_comb begin
    a_idx_s    = AW'(32'(i_r) * N + 32'(k_r));
    b_idx_s    = AW'(32'(k_r) * N + 32'(j_r));
    c_idx_s    = AW'(32'(i_r) * N + 32'(j_r));
    a_op_s     = a_mem_r[a_idx_s];
    b_op_s     = b_mem_r[b_idx_s];
    mac_en_s   = (state_r == MAC);
    mac_last_s = (k_r == IW'(N - 1));
    mac_clr_s  = (state_r == IDLE) && start;
    w_ok_s     = 32'(w_addr) < 32'(NN);
    r_ok_s     = 32'(r_addr) < 32'(NN);
    if (r_ok_s) begin
      r_data = c_mem_r[r_addr];
    end else begin
      r_data = {ACCW{1'b0}};
    end
  end

  matmul_mac #(.DW(DW), .ACCW(ACCW)) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (mac_clr_s),
    .en      (mac_en_s),
    .last    (mac_last_s),
    .relu_en (relu_r),
    .a       (a_op_s),
    .b       (b_op_s),
    .result  (mac_result_s)
  );

  // Operand arrays: written only while idle and for in-range addresses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NN; n++) begin
        a_mem_r[n] <= {DW{1'b0}};
        b_mem_r[n] <= {DW{1'b0}};
      end
    end else if ((state_r == IDLE) && w_ok_s) begin
      if (a_we) a_mem_r[w_addr] <= data_in;
      if (b_we) b_mem_r[w_addr] <= data_in;
    end
  end

  // Run control FSM: index walk, result write-back, handshake and cycle count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      i_r           <= {IW{1'b0}};
      j_r           <= {IW{1'b0}};
      k_r           <= {IW{1'b0}};
      relu_r        <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      cycle_count_r <= 32'd0;
      for (int n = 0; n < NN; n++) begin
        c_mem_r[n] <= {ACCW{1'b0}};
      end
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            i_r           <= {IW{1'b0}};
            j_r           <= {IW{1'b0}};
            k_r           <= {IW{1'b0}};
            relu_r        <= relu;
            cycle_count_r <= 32'd0;
            busy_r        <= 1'b1;
            state_r       <= MAC;
          end
        end
        MAC: begin
          cycle_count_r <= cycle_count_r + 32'd1;
          if (mac_last_s) begin
            c_mem_r[c_idx_s] <= mac_result_s;
            k_r <= {IW{1'b0}};
            if (j_r == IW'(N - 1)) begin
              j_r <= {IW{1'b0}};
              if (i_r == IW'(N - 1)) begin
                i_r     <= {IW{1'b0}};
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
                state_r <= DONE;
              end else begin
                i_r <= i_r + IW'(1);
              end
            end else begin
              j_r <= j_r + IW'(1);
            end
          end else begin
            k_r <= k_r + IW'(1);
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign cycle_count = cycle_count_r;

endmodule

// File: tb/tb_matmul_engine.sv
// Directed bench for matmul_engine: an N=2 and an N=3 instance, a reference
// model that pushes expected C elements to a queue at start, and popped
// comparisons after each done pulse.
module tb_matmul_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_we2, b_we2, a_we3, b_we3, start2, start3, relu;
  logic [3:0]  w_addr, r_addr;
  logic [7:0]  data_in;
  logic        busy2, done2, busy3, done3;
  logic [31:0] r_data2, r_data3, cc2, cc3;

  int tests = 0;
  int fails = 0;
  int ma [16];
  int mb [16];

  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] val;
  } exp_t;
  exp_t sbq [$];

  always #5 clk = ~clk;

  matmul_engine #(.N(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .a_we(a_we2), .b_we(b_we2),
    .w_addr(w_addr[1:0]), .data_in(data_in), .start(start2), .relu(relu),
    .busy(busy2), .done(done2), .r_addr(r_addr[1:0]), .r_data(r_data2),
    .cycle_count(cc2)
  );

  matmul_engine #(.N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .a_we(a_we3), .b_we(b_we3),
    .w_addr(w_addr), .data_in(data_in), .start(start3), .relu(relu),
    .busy(busy3), .done(done3), .r_addr(r_addr), .r_data(r_data3),
    .cycle_count(cc3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic busy_of(input int n);
    return (n == 2) ? busy2 : busy3;
  endfunction

  function automatic logic done_of(input int n);
    return (n == 2) ? done2 : done3;
  endfunction

  function automatic logic [31:0] rdata_of(input int n);
    return (n == 2) ? r_data2 : r_data3;
  endfunction

  function automatic logic [31:0] cc_of(input int n);
    return (n == 2) ? cc2 : cc3;
  endfunction

  task automatic clr_model();
    for (int i = 0; i < 16; i++) begin
      ma[i] = 0;
      mb[i] = 0;
    end
  endtask

  task automatic wr(input int n, input logic is_a, input int addr, input int v);
    @(negedge clk);
    w_addr  = 4'(addr);
    data_in = 8'(v);
    if (n == 2) begin
      a_we2 = is_a; b_we2 = !is_a;
    end else begin
      a_we3 = is_a; b_we3 = !is_a;
    end
    @(negedge clk);
    a_we2 = 1'b0; b_we2 = 1'b0; a_we3 = 1'b0; b_we3 = 1'b0;
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n * n; i++) begin
      wr(n, 1'b1, i, ma[i]);
      wr(n, 1'b0, i, mb[i]);
    end
  endtask

  task automatic push_exp(input int n, input logic r);
    int s;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        s = 0;
        for (int k = 0; k < n; k++) s += ma[i*n+k] * mb[k*n+j];
`ifdef MATMUL_RELU_EN
        if (r && s < 0) s = 0;
`endif
        e.addr = 4'(i * n + j);
        e.val  = 32'(s);
        sbq.push_back(e);
      end
    end
  endtask

  task automatic check_results(input int n);
    exp_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      @(negedge clk);
      r_addr = e.addr;
      #1;
      chk($sformatf("c_n%0d_addr%0d", n, e.addr), rdata_of(n), e.val);
    end
  endtask

  task automatic run(input int n, input logic r, input logic inject);
    int nc = n * n * n;
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_at = 0;
    logic bz_at_done = 1'b1;
    push_exp(n, r);
    @(negedge clk);
    relu = r;
    if (n == 2) start2 = 1'b1; else start3 = 1'b1;
    for (int c = 1; c <= nc + 6; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start2 = 1'b0; start3 = 1'b0; relu = 1'b0;
      end
      if (busy_of(n)) busy_cnt++;
      if (done_of(n)) begin
        done_cnt++;
        if (done_at == 0) begin
          done_at = c;
          bz_at_done = busy_of(n);
        end
      end
      if (inject && c == 3) begin
        w_addr = 4'd0; data_in = 8'h63;
        if (n == 2) begin start2 = 1'b1; a_we2 = 1'b1; end
        else begin start3 = 1'b1; a_we3 = 1'b1; end
      end else if (inject && c == 4) begin
        start2 = 1'b0; start3 = 1'b0; a_we2 = 1'b0; a_we3 = 1'b0;
      end
    end
    chk("busy_cycles", 32'(busy_cnt), 32'(nc));
    chk("done_cycle", 32'(done_at), 32'(nc + 1));
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("busy_at_done", {31'd0, bz_at_done}, 32'd0);
    chk("cycle_count", cc_of(n), 32'(nc));
    check_results(n);
  endtask

  initial begin
    rst_n = 1'b0;
    a_we2 = 1'b0; b_we2 = 1'b0; a_we3 = 1'b0; b_we3 = 1'b0;
    start2 = 1'b0; start3 = 1'b0; relu = 1'b0;
    w_addr = 4'd0; r_addr = 4'd0; data_in = 8'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state of both instances
    @(negedge clk);
    chk("rst_busy2", {31'd0, busy2}, 32'd0);
    chk("rst_done2", {31'd0, done2}, 32'd0);
    chk("rst_cc2", cc2, 32'd0);
    chk("rst_busy3", {31'd0, busy3}, 32'd0);
    chk("rst_cc3", cc3, 32'd0);
    for (int a = 0; a < 9; a++) begin
      r_addr = 4'(a);
      #1;
      chk($sformatf("rst_c3_%0d", a), r_data3, 32'd0);
      if (a < 4) chk($sformatf("rst_c2_%0d", a), r_data2, 32'd0);
    end

    // Basic 2x2 product
    clr_model();
    ma[0] = 1; ma[1] = 2; ma[2] = 3; ma[3] = 4;
    mb[0] = 5; mb[1] = 6; mb[2] = 7; mb[3] = 8;
    load(2);
    run(2, 1'b0, 1'b0);

    // Most negative operands everywhere
    for (int i = 0; i < 4; i++) begin ma[i] = -128; mb[i] = -128; end
    load(2);
    run(2, 1'b0, 1'b0);

    // Negative result with and without the clamp
    ma[0] = -1; ma[1] = 0; ma[2] = 0; ma[3] = 1;
    mb[0] = 1;  mb[1] = 0; mb[2] = 0; mb[3] = 1;
    load(2);
    run(2, 1'b1, 1'b0);
    run(2, 1'b0, 1'b0);

    // start and operand write during a run must have no effect
    ma[0] = 1; ma[1] = 2; ma[2] = 3; ma[3] = 4;
    mb[0] = 5; mb[1] = 6; mb[2] = 7; mb[3] = 8;
    load(2);
    run(2, 1'b0, 1'b1);

    // Reset in MAC cycle 3
    ma[0] = 2; ma[1] = -3; ma[2] = 4; ma[3] = 5;
    mb[0] = 7; mb[1] = 1; mb[2] = -2; mb[3] = 6;
    load(2);
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy2}, 32'd0);
    begin
      int dcnt = 0;
      repeat (4) begin
        @(negedge clk);
        if (done2) dcnt++;
      end
      chk("midrst_no_done", 32'(dcnt), 32'd0);
    end
    rst_n = 1'b1;
    chk("midrst_cc", cc2, 32'd0);
    for (int a = 0; a < 4; a++) begin
      r_addr = 4'(a);
      #1;
      chk($sformatf("midrst_c_%0d", a), r_data2, 32'd0);
    end
    load(2);
    run(2, 1'b0, 1'b0);

    // N=3: identity times 0..8
    clr_model();
    ma[0] = 1; ma[4] = 1; ma[8] = 1;
    for (int i = 0; i < 9; i++) mb[i] = i;
    load(3);
    run(3, 1'b0, 1'b0);

    // N=3 address boundaries
    wr(3, 1'b1, 9, 77);
    wr(3, 1'b0, 9, 55);
    @(negedge clk);
    r_addr = 4'd12;
    #1;
    chk("rd_oob_12", r_data3, 32'd0);
    r_addr = 4'd9;
    #1;
    chk("rd_oob_9", r_data3, 32'd0);
    run(3, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
